// File: rtl/spi_txn_fsm_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave transaction controller:
//   - state_t  : transaction state encoding (4 bits)
//   - RW_READ / RW_WRITE : polarity of the R/W bit that follows the address
//   - max_int  : helper used to size the shared bit counter
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        RW        = 4'd2,
        RD        = 4'd3,
        RD_INC    = 4'd4,
        RD_LOAD   = 4'd5,
        WR        = 4'd6,
        WR_COMMIT = 4'd7,
        DONE      = 4'd8
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_txn_fsm_bit_counter.sv
// ---------------------------------------------------------------------------
// spi_bit_counter
// Loadable bit counter with a terminal-count compare. The same counter is
// reused for the address phase and for every data word; the caller selects
// the terminal value for the current phase.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset (counter -> 0)
//   i_clr      in   synchronous clear to 0 (wins over i_inc)
//   i_inc      in   count one bit
//   i_term     in   terminal count for the current phase
//   o_cnt      out  current count
//   o_at_term  out  o_cnt equals i_term
// ---------------------------------------------------------------------------
module spi_bit_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_term,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_at_term
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_term;

    assign w_at_term = (r_cnt == i_term);

    // The count never runs past the terminal value; the controller clears it
    // on the terminal edge, so holding here only matters for stray strobes.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_term) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_at_term = w_at_term;

endmodule

// File: rtl/spi_txn_fsm.sv
// ---------------------------------------------------------------------------
// spi_txn_fsm
// Sequences one SPI slave transaction: ADDR_W address bits, one R/W bit,
// then one data word (BURST=0) or consecutive words with address
// auto-increment while cs stays low (BURST=1). Sits between the SCLK edge
// detector / input conditioners and the address latch, shift register and
// data memory.
//
// Every output is a register that takes the value belonging to the state
// being entered, so a strobe is high for exactly the clock spent in the
// state that owns it (dm_we in WR_COMMIT, addr_inc in RD_INC/WR_COMMIT,
// sr_we in RD_LOAD and in the first RD clock after the R/W bit).
//
// Parameters:
//   ADDR_W  address bits per transaction (>=1)
//   DATA_W  bits per data word (>=2)
//   BURST   1 = auto-increment and continue words, 0 = single word
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   synchronous active-low reset
//   sclk_edge  in   one-clk strobe per conditioned SCLK rising edge
//   cs         in   chip select, active low (conditioned)
//   rw         in   R/W bit (shift register LSB), 1 = read
//   miso_buff  out  MISO tristate enable
//   addr_we    out  address latch write enable (level)
//   sr_we      out  shift register parallel load (1-clk pulse)
//   dm_we      out  data memory write (1-clk pulse)
//   addr_inc   out  address latch increment (1-clk pulse, BURST only)
//   busy       out  high whenever the state is not IDLE
//   abort      out  only with SPI_TXN_ABORT_FLAG_EN: cs rose mid-field
//
// Build option: define SPI_TXN_ABORT_FLAG_EN to add the abort output.
// ---------------------------------------------------------------------------
module spi_txn_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter bit BURST  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk_edge,
    input  logic cs,
    input  logic rw,
    output logic miso_buff,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic addr_inc,
    output logic busy
`ifdef SPI_TXN_ABORT_FLAG_EN
    ,
    output logic abort
`endif
);

    localparam int CNT_W = $clog2(max_int(ADDR_W, DATA_W));
    localparam logic [CNT_W-1:0] ADDR_TC = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_W - 1);

    state_t           r_state;
    logic             r_miso_buff;
    logic             r_addr_we;
    logic             r_sr_we;
    logic             r_dm_we;
    logic             r_addr_inc;
    logic             r_busy;

    logic             w_shift_phase;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_at_term;
    logic [CNT_W-1:0] w_term;
    logic [CNT_W-1:0] w_cnt;

    // -----------------------------------------------------------------------
    // Bit counter control. Only ADDR, RD and WR count SCLK edges; the
    // counter is cleared on the terminal edge of each field, whenever cs is
    // high and while idle, and simply holds in the other states.
    // -----------------------------------------------------------------------
    always_comb begin
        w_shift_phase = (r_state == ADDR) || (r_state == RD) || (r_state == WR);
        w_term        = (r_state == ADDR) ? ADDR_TC : DATA_TC;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        if (cs || (r_state == IDLE)) begin
            w_cnt_clr = 1'b1;
        end else if (w_shift_phase && sclk_edge) begin
            if (w_at_term) begin
                w_cnt_clr = 1'b1;
            end else begin
                w_cnt_inc = 1'b1;
            end
        end
    end

    spi_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_cnt_clr),
        .i_inc     (w_cnt_inc),
        .i_term    (w_term),
        .o_cnt     (w_cnt),
        .o_at_term (w_at_term)
    );

`ifdef SPI_TXN_ABORT_FLAG_EN
    logic r_abort;
    logic w_abort_cond;

    // A cs rise counts as an abort when a field is part-way shifted in, or
    // when the address is complete but the R/W bit has not arrived yet.
    assign w_abort_cond = (r_state == RW) || (w_shift_phase && (w_cnt != '0));
`else
    // The count value itself is only observed by the abort flag.
    logic w_unused_cnt;
    assign w_unused_cnt = |w_cnt;
`endif

    // -----------------------------------------------------------------------
    // Transaction state machine. cs high returns to IDLE from any state and
    // drops every output; a part-shifted write word is thereby discarded
    // before WR_COMMIT can raise dm_we.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_miso_buff <= 1'b0;
            r_addr_we   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_addr_inc  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SPI_TXN_ABORT_FLAG_EN
            r_abort     <= 1'b0;
`endif
        end else if (cs) begin
            r_state     <= IDLE;
            r_miso_buff <= 1'b0;
            r_addr_we   <= 1'b0;
            r_sr_we     <= 1'b0;
            r_dm_we     <= 1'b0;
            r_addr_inc  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SPI_TXN_ABORT_FLAG_EN
            if (w_abort_cond) begin
                r_abort <= 1'b1;
            end
`endif
        end else begin
            // Strobes default low so each lasts exactly one clock.
            r_sr_we    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_addr_inc <= 1'b0;
            r_busy     <= 1'b1;

            case (r_state)
                IDLE: begin
                    r_state   <= ADDR;
                    r_addr_we <= 1'b1;
`ifdef SPI_TXN_ABORT_FLAG_EN
                    r_abort   <= 1'b0;
`endif
                end

                ADDR: begin
                    if (sclk_edge && w_at_term) begin
                        r_addr_we <= 1'b0;
                        r_state   <= RW;
                    end
                end

                RW: begin
                    if (sclk_edge) begin
                        if (rw == RW_READ) begin
                            r_sr_we     <= 1'b1;
                            r_miso_buff <= 1'b1;
                            r_state     <= RD;
                        end else begin
                            r_state     <= WR;
                        end
                    end
                end

                RD: begin
                    if (sclk_edge && w_at_term) begin
                        if (BURST) begin
                            r_addr_inc  <= 1'b1;
                            r_state     <= RD_INC;
                        end else begin
                            r_miso_buff <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end

                // Address bumps first, then the shift register loads the
                // word from the new address one clock later.
                RD_INC: begin
                    r_sr_we <= 1'b1;
                    r_state <= RD_LOAD;
                end

                RD_LOAD: begin
                    r_state <= RD;
                end

                // dm_we and addr_inc share the WR_COMMIT clock: the memory
                // captures the old address on the same edge that increments it.
                WR: begin
                    if (sclk_edge && w_at_term) begin
                        r_dm_we    <= 1'b1;
                        r_addr_inc <= BURST;
                        r_state    <= WR_COMMIT;
                    end
                end

                WR_COMMIT: begin
                    r_state <= BURST ? WR : DONE;
                end

                DONE: begin
                    r_state <= DONE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign miso_buff = r_miso_buff;
    assign addr_we   = r_addr_we;
    assign sr_we     = r_sr_we;
    assign dm_we     = r_dm_we;
    assign addr_inc  = r_addr_inc;
    assign busy      = r_busy;
`ifdef SPI_TXN_ABORT_FLAG_EN
    assign abort     = r_abort;
`endif

endmodule

// File: tb/tb_spi_txn_fsm.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_fsm
// Drives a single-word (BURST=0) and a burst (BURST=1) controller from the
// same stimulus. Expected outputs come from a transaction-level model that
// records the clock index of every accepted SCLK edge and derives each
// output from edge positions (address field, R/W edge, word terminal edges).
// ---------------------------------------------------------------------------
module tb_spi_txn_fsm;

    localparam int A = 7;
    localparam int D = 8;

    typedef struct {
        bit rst_n;
        bit cs;
        bit se;
        bit rw;
    } step_t;

    logic clk = 1'b0;
    logic reset_n;
    logic sclk_edge;
    logic cs;
    logic rw;

    logic miso_s, awe_s, srwe_s, dm_s, ainc_s, busy_s, ab_s;
    logic miso_b, awe_b, srwe_b, dm_b, ainc_b, busy_b, ab_b;
    logic [6:0] obs_s, obs_b;

    always #5 clk = ~clk;

    spi_txn_fsm #(.ADDR_W(A), .DATA_W(D), .BURST(1'b0)) u_single (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk_edge (sclk_edge),
        .cs        (cs),
        .rw        (rw),
        .miso_buff (miso_s),
        .addr_we   (awe_s),
        .sr_we     (srwe_s),
        .dm_we     (dm_s),
        .addr_inc  (ainc_s),
        .busy      (busy_s)
`ifdef SPI_TXN_ABORT_FLAG_EN
        ,
        .abort     (ab_s)
`endif
    );

    spi_txn_fsm #(.ADDR_W(A), .DATA_W(D), .BURST(1'b1)) u_burst (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk_edge (sclk_edge),
        .cs        (cs),
        .rw        (rw),
        .miso_buff (miso_b),
        .addr_we   (awe_b),
        .sr_we     (srwe_b),
        .dm_we     (dm_b),
        .addr_inc  (ainc_b),
        .busy      (busy_b)
`ifdef SPI_TXN_ABORT_FLAG_EN
        ,
        .abort     (ab_b)
`endif
    );

`ifndef SPI_TXN_ABORT_FLAG_EN
    assign ab_s = 1'b0;
    assign ab_b = 1'b0;
`endif

    assign obs_s = {ab_s, miso_s, awe_s, srwe_s, dm_s, ainc_s, busy_s};
    assign obs_b = {ab_b, miso_b, awe_b, srwe_b, dm_b, ainc_b, busy_b};

    int    vectors = 0;
    int    errors  = 0;
    step_t plan[$];
    step_t cur;
    logic [6:0] exp_s, exp_b;

    // Reference model state
    int cyc = 0;
    bit m_active = 1'b0;
    int m_edges[$];
    bit m_rw = 1'b0;
    bit m_abort_s = 1'b0;
    bit m_abort_b = 1'b0;

    // Abort when cs rises with a field part-shifted or right after the address.
    function automatic bit abort_cond(input bit burst);
        int n = m_edges.size();
        if (n < A) return (n != 0);
        if (n == A) return 1'b1;
        if (!burst && (n >= A + 1 + D)) return 1'b0;
        return (((n - A - 1) % D) != 0);
    endfunction

    // Outputs after the current clock, from accepted-edge positions:
    // edges[0..A-1] address, edges[A] R/W, edges[A+k*D] end of word k.
    function automatic logic [6:0] model_exp(input bit burst);
        logic ab, miso, awe, srwe, dmwe, ainc;
        int n, t;
        ab = burst ? m_abort_b : m_abort_s;
`ifndef SPI_TXN_ABORT_FLAG_EN
        ab = 1'b0;
`endif
        if (!m_active) return {ab, 6'b0};
        n = m_edges.size();
        awe = (n < A);
        miso = 1'b0; srwe = 1'b0; dmwe = 1'b0; ainc = 1'b0;
        if (n > A) begin
            if (m_rw) begin
                miso = 1'b1;
                srwe = (cyc == m_edges[A]);
            end
            for (int k = 1; A + k * D < n; k++) begin
                if (!burst && k > 1) break;
                t = m_edges[A + k * D];
                if (!m_rw) begin
                    if (cyc == t) begin
                        dmwe = 1'b1;
                        ainc = burst;
                    end
                end else if (!burst) begin
                    miso = 1'b0;
                end else begin
                    if (cyc == t) ainc = 1'b1;
                    if (cyc == t + 1) srwe = 1'b1;
                end
            end
        end
        return {ab, miso, awe, srwe, dmwe, ainc, 1'b1};
    endfunction

    task automatic model_update(input step_t s);
        cyc++;
        if (!s.rst_n) begin
            m_active  = 1'b0;
            m_abort_s = 1'b0;
            m_abort_b = 1'b0;
        end else if (s.cs) begin
            if (m_active) begin
                if (abort_cond(1'b0)) m_abort_s = 1'b1;
                if (abort_cond(1'b1)) m_abort_b = 1'b1;
            end
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_edges.delete();
            m_abort_s = 1'b0;
            m_abort_b = 1'b0;
        end else if (s.se) begin
            m_edges.push_back(cyc);
            if (m_edges.size() == A + 1) m_rw = s.rw;
        end
    endtask

    // Apply one planned clock of stimulus and advance the model.
    task automatic run_cycle();
        cur = plan.pop_front();
        reset_n   = cur.rst_n;
        cs        = cur.cs;
        sclk_edge = cur.se;
        rw        = cur.rw;
        @(posedge clk);
        #1;
        model_update(cur);
        exp_s = model_exp(1'b0);
        exp_b = model_exp(1'b1);
    endtask

    function automatic step_t quiet();
        step_t s;
        s = '{1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1))};
        return s;
    endfunction

    // tail: 0 = settle then cs high, 1 = cs high right after last edge,
    //       2 = cs rises on the last edge, 3 = reset shortly after last edge
    task automatic build_txn(input int nedges, input bit rwbit, input int tail);
        step_t s;
        plan.push_back(quiet());
        for (int i = 0; i < nedges; i++) begin
            int gap;
            gap = $urandom_range(3, 5);
            for (int g = 1; g < gap; g++) plan.push_back(quiet());
            s = '{1'b1, 1'((tail == 2) && (i == nedges - 1)), 1'b1,
                  (i == A) ? rwbit : 1'($urandom_range(0, 1))};
            plan.push_back(s);
        end
        if (tail == 3) begin
            plan.push_back(quiet());
            plan.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        end else begin
            if (tail == 0) repeat (3) plan.push_back(quiet());
            if (tail != 2 || nedges == 0) plan.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
            plan.push_back('{1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0});
        end
    endtask

    task automatic test_reset();
        plan.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        plan.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        while (plan.size() > 0) begin
            run_cycle();
            vectors++;
            if (obs_s !== 7'b0) begin
                errors++;
                $display("FAIL reset single cyc=%0d got=%b exp=%b", cyc, obs_s, 7'b0);
            end
            vectors++;
            if (obs_b !== 7'b0) begin
                errors++;
                $display("FAIL reset burst cyc=%0d got=%b exp=%b", cyc, obs_b, 7'b0);
            end
        end
        plan.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        run_cycle();
    endtask

    task automatic test_single_word();
        build_txn(A + 1 + D, 1'b0, 0);
        build_txn(A + 1 + D, 1'b1, 0);
        while (plan.size() > 0) begin
            run_cycle();
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL single_word single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL single_word burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_burst_write();
        int n_dm_b = 0, n_co_b = 0, n_dm_s = 0, n_inc_s = 0;
        build_txn(A + 1 + 3 * D, 1'b0, 0);
        while (plan.size() > 0) begin
            run_cycle();
            if (dm_b === 1'b1) n_dm_b++;
            if (dm_b === 1'b1 && ainc_b === 1'b1) n_co_b++;
            if (dm_s === 1'b1) n_dm_s++;
            if (ainc_s === 1'b1) n_inc_s++;
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL burst_write single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL burst_write burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
        vectors++;
        if (n_dm_b !== 3) begin
            errors++;
            $display("FAIL burst_write_dm_count got=%0d exp=3", n_dm_b);
        end
        vectors++;
        if (n_co_b !== 3) begin
            errors++;
            $display("FAIL burst_write_inc_coincident got=%0d exp=3", n_co_b);
        end
        vectors++;
        if (n_dm_s !== 1 || n_inc_s !== 0) begin
            errors++;
            $display("FAIL single_write_pulses got dm=%0d inc=%0d exp dm=1 inc=0", n_dm_s, n_inc_s);
        end
    endtask

    task automatic test_burst_read();
        int n_inc = 0, n_sr = 0;
        build_txn(A + 1 + 2 * D, 1'b1, 0);
        while (plan.size() > 0) begin
            run_cycle();
            if (ainc_b === 1'b1) n_inc++;
            if (srwe_b === 1'b1) n_sr++;
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL burst_read single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL burst_read burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
        vectors++;
        if (n_inc !== 2 || n_sr !== 3) begin
            errors++;
            $display("FAIL burst_read_pulses got inc=%0d sr=%0d exp inc=2 sr=3", n_inc, n_sr);
        end
    endtask

    task automatic test_abort();
        int n_dm = 0;
        build_txn(A + 1 + 4, 1'b0, 1);
        build_txn(A + 1 + D, 1'b0, 2);
        build_txn(A, 1'b1, 1);
        repeat (3) plan.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
        build_txn(2, 1'b0, 1);
        while (plan.size() > 0) begin
            run_cycle();
            if (dm_s === 1'b1 || dm_b === 1'b1) n_dm++;
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL abort single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL abort burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
        vectors++;
        if (n_dm !== 0) begin
            errors++;
            $display("FAIL abort_no_dm_we got=%0d exp=0", n_dm);
        end
    endtask

    task automatic test_reset_mid_read();
        build_txn(A + 1 + 3, 1'b1, 3);
        build_txn(A + 1 + D, 1'b1, 0);
        while (plan.size() > 0) begin
            run_cycle();
            if (!cur.rst_n) begin
                vectors++;
                if (obs_b !== 7'b0 || obs_s !== 7'b0) begin
                    errors++;
                    $display("FAIL reset_mid_read_clear got=%b/%b exp=0", obs_s, obs_b);
                end
            end
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL reset_mid_read single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL reset_mid_read burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 24; t++) begin
            build_txn($urandom_range(0, A + 1 + 3 * D + 2), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2));
        end
        while (plan.size() > 0) begin
            run_cycle();
            vectors++;
            if (obs_s !== exp_s) begin
                errors++;
                $display("FAIL back_to_back single cyc=%0d got=%b exp=%b", cyc, obs_s, exp_s);
            end
            vectors++;
            if (obs_b !== exp_b) begin
                errors++;
                $display("FAIL back_to_back burst cyc=%0d got=%b exp=%b", cyc, obs_b, exp_b);
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        cs        = 1'b1;
        sclk_edge = 1'b0;
        rw        = 1'b0;
        test_reset();
        test_single_word();
        test_burst_write();
        test_burst_read();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/spi_txn_fsm.md
Name: spi_txn_fsm

Overview:
- Parametrised successor to the SPI slave transaction controller.
- Sequences one SPI slave transaction: ADDR_W address bits, one R/W bit, then one or more DATA_W data words.
- Drives address-register capture, shift-register parallel load, data-memory write, MISO tristate enable and burst address increment.
- Sits between the SCLK edge detector/input conditioners and the address latch, shift register and data memory.

Parameters:
- ADDR_W, 7, address bits per transaction (>=1).
- DATA_W, 8, bits per data word (>=2).
- BURST, 0, 1 = auto-increment address and continue words while cs low; 0 = single word.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- sclk_edge  in  1  one-clk strobe per SCLK rising edge (conditioned).
- cs  in  1  chip select, active low (conditioned).
- rw  in  1  R/W bit (shift register LSB); 1 = read, 0 = write.
- miso_buff  out  1  MISO tristate enable.
- addr_we  out  1  address latch write enable (level).
- sr_we  out  1  shift-register parallel load (1-clk pulse).
- dm_we  out  1  data-memory write (1-clk pulse).
- addr_inc  out  1  address latch increment (1-clk pulse, BURST only).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - State IDLE, bit counter 0.
  - All outputs 0.
  - Reset has priority over cs.
- cs=1 on any clk, any state:
  - Next state IDLE, counter 0, all outputs 0.
  - A partially shifted write word is discarded; dm_we is never asserted.
- Counter width: $clog2(max(ADDR_W,DATA_W)). Compares are exact; no wrap beyond the terminal count.
- IDLE: on cs=0 (no sclk_edge needed) go to ADDR, set addr_we=1, counter 0.
- ADDR:
  - Each sclk_edge increments the counter.
  - On the edge where counter==ADDR_W-1: addr_we=0, counter 0, go to RW.
- RW, on sclk_edge:
  - rw=1: sr_we pulse, miso_buff=1, go to RD.
  - rw=0: go to WR.
- RD:
  - Each sclk_edge increments the counter.
  - On the edge where counter==DATA_W-1, counter 0, then:
    - BURST=1: go to RD_INC.
    - BURST=0: miso_buff=0, go to DONE.
- RD_INC (1 clk, not edge-gated): addr_inc pulse, go to RD_LOAD.
- RD_LOAD (1 clk): sr_we pulse, go to RD. miso_buff stays 1 throughout.
- WR:
  - Each sclk_edge increments the counter.
  - On the edge where counter==DATA_W-1: counter 0, go to WR_COMMIT.
- WR_COMMIT (1 clk):
  - dm_we pulse; addr_inc pulse in the same cycle if BURST=1.
  - Memory samples the old address at this edge.
  - Next state: WR if BURST=1, else DONE.
- DONE: all strobes 0; hold until cs=1.
- Timing constraint: consecutive sclk_edge strobes are >=3 clk apart. An sclk_edge arriving during RD_INC, RD_LOAD or WR_COMMIT is a protocol violation (behaviour undefined; flagged in verification only).
- sclk_edge with cs=1 is ignored.
- Simultaneous cs rise and terminal edge: cs wins; no dm_we, no addr_inc.
- Pulses are exactly one clk wide; levels change only on posedge clk.

Optional Feature:
- Macro SPI_TXN_ABORT_FLAG_EN.
- When defined: extra output abort (1 bit, reset 0).
  - abort is set on the clk where cs rises while state is ADDR, RW, RD or WR with counter != 0, or while in RW.
  - abort clears on the next IDLE->ADDR transition.
- When undefined: port absent; behaviour otherwise identical.

Decomposition:
- Package spi_pkg: state enum (IDLE, ADDR, RW, RD, RD_INC, RD_LOAD, WR, WR_COMMIT, DONE) with 4-bit encoding; R/W polarity constants RW_READ=1 and RW_WRITE=0.
- One natural sub-module, spi_bit_counter: loadable, terminal-count-compare counter, reused for address and data phases.

Test Plan (ADDR_W=7, DATA_W=8):
- Write, BURST=0: cs low, 7 addr edges, rw=0, 8 edges -> addr_we high for exactly 7 edges; single dm_we pulse 1 clk after the 16th edge; no addr_inc.
- Read, BURST=0: rw=1 -> sr_we pulse on the RW edge; miso_buff high for 8 edges then 0; DONE until cs=1.
- Burst write, BURST=1: 3 words -> 3 dm_we pulses, each coincident with an addr_inc pulse, spaced 8 edges apart.
- Burst read, BURST=1: 2 words -> after word 1, addr_inc at clk N and sr_we at clk N+1; miso_buff continuously 1.
- Abort: cs rises after the 4th data edge of a write -> no dm_we, state IDLE next clk; with SPI_TXN_ABORT_FLAG_EN, abort=1 until the next cs fall.
- Reset mid-read: reset_n=0 during RD -> all outputs 0 and busy 0 next clk; a new transaction after release behaves normally.
